// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus (imem handshake, redirect, decode handoff, perf counters)
interface instruction_fetch_if #(parameter int WORD_SIZE = 32);
  logic imem_req, imem_gnt, imem_rvalid, redirect_valid, if_valid, id_ready;
  logic [WORD_SIZE-1:0] imem_addr, imem_rdata, redirect_pc, if_instruction, if_pc, if_pc_plus4;
  logic [31:0] perf_fetch_count, perf_flush_count;
  modport master (
    output imem_req, imem_addr, if_valid, if_instruction, if_pc, if_pc_plus4,
           perf_fetch_count, perf_flush_count,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instruction, if_pc, if_pc_plus4,
           perf_fetch_count, perf_flush_count,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch FSM with redirect/flush; IFETCH_PERF_CNT_EN adds perf counters
module instruction_fetch #(
  parameter int WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  state_e state_q;
  logic drop_q, if_valid_q, take_d, grant_d;
  logic [WORD_SIZE-1:0] pc_q, pc_plus4_d, redirect_pc_d;
  logic [WORD_SIZE-1:0] if_instruction_q, if_pc_q, if_pc_plus4_q;
  assign pc_plus4_d = pc_q + WORD_SIZE'(4);
  assign redirect_pc_d = bus.redirect_pc & ~WORD_SIZE'(3);
  // a consumed held instruction issues the next request in the same cycle
  assign take_d = (state_q == HOLD) && bus.id_ready;
  assign bus.imem_req = ((state_q == REQ) || take_d) && !bus.redirect_valid;
  assign grant_d = bus.imem_req && bus.imem_gnt;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_instruction = if_instruction_q;
  assign bus.if_pc = if_pc_q;
  assign bus.if_pc_plus4 = if_pc_plus4_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      drop_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_instruction_q <= '0;
      if_pc_q <= '0;
      if_pc_plus4_q <= '0;
    end else if (bus.redirect_valid) begin
      pc_q <= redirect_pc_d;
      if_valid_q <= 1'b0;
      drop_q <= (state_q == WAIT) && !bus.imem_rvalid;
      state_q <= ((state_q == WAIT) && !bus.imem_rvalid) ? WAIT : REQ;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ:  state_q <= grant_d ? WAIT : REQ;
        WAIT: if (bus.imem_rvalid) begin
          if (drop_q) begin
            drop_q <= 1'b0;
            state_q <= REQ;
          end else begin
            if_instruction_q <= bus.imem_rdata;
            if_pc_q <= pc_q;
            if_pc_plus4_q <= pc_plus4_d;
            if_valid_q <= 1'b1;
            pc_q <= pc_plus4_d;
            state_q <= HOLD;
          end
        end
        HOLD: if (bus.id_ready) begin
          if_valid_q <= 1'b0;
          state_q <= grant_d ? WAIT : REQ;
        end
      endcase
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  logic fetch_inc_d, flush_inc_d;
  assign fetch_inc_d = if_valid_q && bus.id_ready && !bus.redirect_valid;
  assign flush_inc_d = (bus.redirect_valid && (state_q == HOLD)) ||
                       ((state_q == WAIT) && bus.imem_rvalid && (drop_q || bus.redirect_valid));
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(fetch_inc_d);
      flush_cnt_q <= flush_cnt_q + 32'(flush_inc_d);
    end
  end
  assign bus.perf_fetch_count = fetch_cnt_q;
  assign bus.perf_flush_count = flush_cnt_q;
`else
  assign bus.perf_fetch_count = '0;
  assign bus.perf_flush_count = '0;
`endif
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter WORD_SIZE, default 32, SHALL set the width of PC, address and instruction words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded at reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-006 imem_addr  output  WORD_SIZE  SHALL be the fetch address (current PC).
REQ-007 imem_gnt  input  1  SHALL indicate memory accepted imem_req this cycle.
REQ-008 imem_rvalid  input  1  SHALL mark a valid response (at least 1 cycle after grant, in order).
REQ-009 imem_rdata  input  WORD_SIZE  SHALL be the response instruction word.
REQ-010 redirect_valid  input  1  SHALL request a PC change (branch/jump) from a later stage.
REQ-011 redirect_pc  input  WORD_SIZE  SHALL be the redirect target; bits [1:0] ignored (treated as 0).
REQ-012 if_valid  output  1  SHALL mark a valid fetched instruction for the decode stage.
REQ-013 if_instruction  output  WORD_SIZE  SHALL be the fetched word fed to instruction_decode.
REQ-014 if_pc / if_pc_plus4  output  WORD_SIZE each  SHALL be the instruction's PC and PC+4.
REQ-015 id_ready  input  1  SHALL indicate decode consumes the instruction this cycle.
REQ-016 perf_fetch_count / perf_flush_count  output  32 each  SHALL be the performance counters (REQ-033).

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD; at most one memory request SHALL be outstanding.
REQ-018 IDLE: imem_req=0; SHALL go to REQ the following cycle.
REQ-019 REQ: imem_req=1, imem_addr=pc; on imem_gnt SHALL go to WAIT, else stay in REQ.
REQ-020 WAIT: on imem_rvalid with drop flag clear, SHALL load if_instruction=imem_rdata, if_pc=pc, if_pc_plus4=pc+4, set if_valid, set pc<=pc+4, and go to HOLD.
REQ-021 WAIT: on imem_rvalid with drop flag set, SHALL discard data, clear drop, and go to REQ.
REQ-022 HOLD: if_valid=1; all if_* outputs SHALL stay stable while id_ready=0.
REQ-023 HOLD with id_ready=1: if_valid SHALL clear next cycle; imem_req=1 in that same cycle; go to WAIT on imem_gnt, else to REQ.
REQ-024 Throughput with 1-cycle memory and id_ready=1 SHALL be one instruction per 2 cycles; grant-to-if_valid latency SHALL be 2 cycles.
REQ-025 PC+4 SHALL wrap modulo 2^WORD_SIZE.
REQ-026 redirect_valid SHALL have priority over all other events: pc<=redirect_pc&~3, and if_valid SHALL be 0 next cycle.
REQ-027 While redirect_valid=1, imem_req SHALL be 0 (combinationally masked); REQ stays in REQ.
REQ-028 Redirect in WAIT without imem_rvalid SHALL set the drop flag and stay in WAIT; with imem_rvalid in the same cycle, the data SHALL be discarded and the FSM SHALL go to REQ.
REQ-029 Redirect in HOLD SHALL flush the held instruction (even if id_ready=1) and go to REQ.
REQ-030 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-031 rst=1 SHALL set: state=IDLE, pc=RESET_PC, drop=0, if_valid=0, if_instruction=0, if_pc=0, if_pc_plus4=0, counters=0.
REQ-032 Reset mid-request SHALL abandon any outstanding response; a late imem_rvalid SHALL be ignored (REQ-030).

Configuration
REQ-033 With IFETCH_PERF_CNT_EN defined: perf_fetch_count SHALL increment on each if_valid&&id_ready cycle without redirect; perf_flush_count SHALL increment per dropped response or flushed held instruction; both wrap at 2^32.
REQ-034 Without IFETCH_PERF_CNT_EN: both ports SHALL be present and tied to 0, with no counter registers.

Verification
REQ-035 Reset, 1-cycle memory returning addr, id_ready=1 -> if_pc sequence 0x0,0x4,0x8 with if_valid every 2nd cycle.
REQ-036 id_ready=0 for 5 cycles in HOLD -> if_instruction/if_pc stable, imem_req=0 throughout.
REQ-037 Redirect to 0x100 in WAIT, rvalid 2 cycles later -> response dropped, next imem_addr=0x100, if_pc=0x100.
REQ-038 Redirect to 0x203 in HOLD with id_ready=1 -> held instruction not delivered, next imem_addr=0x200.
REQ-039 pc=0xFFFF_FFFC fetched -> if_pc_plus4=0x0, next imem_addr=0x0.
REQ-040 With IFETCH_PERF_CNT_EN: 3 delivered plus 1 flush -> perf_fetch_count=3, perf_flush_count=1; without the macro both read 0.
